// File: rtl/renkon_ctrl_sched.sv
// Layer scheduler for one renkon core: walks output groups x input channels, issuing
// weight-load and image-read sweeps and handing core_state to the conv/accum controller.
module renkon_ctrl_sched #(
  parameter int LWIDTH  = 10,
  parameter int CWIDTH  = 10,
  parameter int IMGADDR = 12,
  parameter int WADDR   = 10
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [CWIDTH-1:0]  total_in,
  input  logic [CWIDTH-1:0]  total_out,
  input  logic [LWIDTH-1:0]  img_size,
  input  logic [LWIDTH-1:0]  fil_size,
  input  logic               out_done,
  output logic               ack,
  output logic               cfg_err,
  output logic [1:0]         core_state,
  output logic               conv_start,
  output logic               img_valid,
  output logic [IMGADDR-1:0] img_addr,
  output logic               net_we,
  output logic [WADDR-1:0]   net_addr,
  output logic               first_input,
  output logic               last_input
);

  localparam logic [1:0] S_WAIT    = 2'd0;
  localparam logic [1:0] S_NETWORK = 2'd1;
  localparam logic [1:0] S_INPUT   = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  logic [CWIDTH-1:0]  tin, tout, in_ch, grp;
  logic [LWIDTH-1:0]  img, fil, row, col, lim;
  logic               lead;
  logic [WADDR-1:0]   nptr;
  logic [IMGADDR-1:0] iptr;
  logic               col_end, sweep_end, ch_last, grp_last, cfg_bad;

  // Kernel and image sweeps share one row/col walker; only the side length differs.
  always_comb begin
    lim       = (core_state == S_NETWORK) ? fil : img;
    col_end   = (col == lim - LWIDTH'(1));
    sweep_end = col_end && (row == lim - LWIDTH'(1));
    ch_last   = (in_ch == tin - CWIDTH'(1));
    grp_last  = (grp == tout - CWIDTH'(1));
    cfg_bad   = (total_in == '0) || (total_out == '0) || (fil_size == '0) ||
                (fil_size > img_size);
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      core_state  <= S_WAIT;
      ack         <= 1'b0;
      cfg_err     <= 1'b0;
      conv_start  <= 1'b0;
      img_valid   <= 1'b0;
      img_addr    <= '0;
      net_we      <= 1'b0;
      net_addr    <= '0;
      first_input <= 1'b0;
      last_input  <= 1'b0;
      tin         <= '0;
      tout        <= '0;
      img         <= '0;
      fil         <= '0;
      in_ch       <= '0;
      grp         <= '0;
      row         <= '0;
      col         <= '0;
      lead        <= 1'b0;
      nptr        <= '0;
      iptr        <= '0;
    end else begin
      ack        <= 1'b0;
      cfg_err    <= 1'b0;
      conv_start <= 1'b0;
      net_we     <= 1'b0;
      img_valid  <= 1'b0;
      case (core_state)
        S_WAIT: begin
          if (req) begin
            tin  <= total_in;
            tout <= total_out;
            img  <= img_size;
            fil  <= fil_size;
            if (cfg_bad) begin
              ack     <= 1'b1;
              cfg_err <= 1'b1;
            end else begin
              core_state  <= S_NETWORK;
              conv_start  <= 1'b1;
              net_we      <= 1'b1;
              net_addr    <= '0;
              nptr        <= WADDR'(1);
              iptr        <= '0;
              in_ch       <= '0;
              grp         <= '0;
              row         <= '0;
              col         <= '0;
              first_input <= 1'b1;
              last_input  <= (total_in == CWIDTH'(1));
            end
          end
        end
        S_NETWORK: begin
          if (sweep_end) begin
            core_state <= S_INPUT;
            row        <= '0;
            col        <= '0;
            lead       <= 1'b1;
          end else begin
            if (col_end) begin
              col <= '0;
              row <= row + LWIDTH'(1);
            end else begin
              col <= col + LWIDTH'(1);
            end
            net_we   <= 1'b1;
            net_addr <= nptr;
            nptr     <= nptr + WADDR'(1);
          end
        end
        S_INPUT: begin
          // Lead cycle lets the consumer register core_state before pixels arrive.
          if (lead) begin
            lead      <= 1'b0;
            img_valid <= 1'b1;
            img_addr  <= iptr;
            iptr      <= iptr + IMGADDR'(1);
          end else if (sweep_end) begin
            row <= '0;
            col <= '0;
            if (!ch_last) begin
              core_state  <= S_NETWORK;
              in_ch       <= in_ch + CWIDTH'(1);
              first_input <= 1'b0;
              last_input  <= (in_ch + CWIDTH'(1) == tin - CWIDTH'(1));
              net_we      <= 1'b1;
              net_addr    <= nptr;
              nptr        <= nptr + WADDR'(1);
            end else begin
              core_state <= S_OUTPUT;
            end
          end else begin
            if (col_end) begin
              col <= '0;
              row <= row + LWIDTH'(1);
            end else begin
              col <= col + LWIDTH'(1);
            end
            img_valid <= 1'b1;
            img_addr  <= iptr;
            iptr      <= iptr + IMGADDR'(1);
          end
        end
        default: begin
          if (out_done) begin
            if (!grp_last) begin
              core_state  <= S_NETWORK;
              grp         <= grp + CWIDTH'(1);
              in_ch       <= '0;
              conv_start  <= 1'b1;
              net_we      <= 1'b1;
              net_addr    <= '0;
              nptr        <= WADDR'(1);
              iptr        <= '0;
              first_input <= 1'b1;
              last_input  <= (tin == CWIDTH'(1));
            end else begin
              core_state  <= S_WAIT;
              ack         <= 1'b1;
              first_input <= 1'b0;
              last_input  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
